// File: rtl/ram_dual_port_param.sv
// ram_dual_port_param: true dual-port RAM with registered reads, byte enables and post-reset clear sweep
//
// Ports:
//   clk                   single clock, all state changes on posedge
//   rst                   asynchronous active-high reset; restarts the clear sweep
//   busy                  high while the clear sweep runs; port requests are ignored
//   en_x, we_x            access enable and write select for port x (a or b)
//   be_x                  per-byte write enables, bit i covers d_x[8i+7:8i]
//   a_x, d_x              address and write data
//   q_x, vld_x            registered read data and its one-cycle valid strobe
//   coll                  (only with RAM_DP_COLLISION_FLAG_EN) same-address write collision pulse
//
// Optional macro RAM_DP_COLLISION_FLAG_EN adds the coll output; data behaviour is unchanged.
module ram_dual_port_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [DATA_W/8-1:0]   be_a,
    input  logic [ADDR_W-1:0]     a_a,
    input  logic [DATA_W-1:0]     d_a,
    output logic [DATA_W-1:0]     q_a,
    output logic                  vld_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [DATA_W/8-1:0]   be_b,
    input  logic [ADDR_W-1:0]     a_b,
    input  logic [DATA_W-1:0]     d_b,
    output logic [DATA_W-1:0]     q_b,
    output logic                  vld_b
`ifdef RAM_DP_COLLISION_FLAG_EN
    ,
    output logic                  coll
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB = DATA_W / 8;
    localparam logic CLEAR = 1'b0;
    localparam logic RUN = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              state;
    logic [ADDR_W-1:0] ptr;
    logic              run, rd_a, rd_b, wr_a, wr_b;

    assign run  = state == RUN;
    assign busy = !run;
    assign rd_a = run & en_a & ~we_a;
    assign rd_b = run & en_b & ~we_b;
    assign wr_a = run & en_a & we_a;
    assign wr_b = run & en_b & we_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            q_a   <= '0;
            q_b   <= '0;
            vld_a <= 1'b0;
            vld_b <= 1'b0;
        end else begin
            if (!run) begin
                ptr <= ptr + 1'b1;
                if (&ptr) state <= RUN;
            end
            vld_a <= rd_a;
            vld_b <= rd_b;
            // reads sample the array before this edge's writes land: read-first
            if (rd_a) q_a <= mem[a_a];
            if (rd_b) q_b <= mem[a_b];
        end
    end

    // B lanes are assigned before A lanes so A overrides on a shared address and lane
    always_ff @(posedge clk) begin
        if (!run) mem[ptr] <= '0;
        else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && be_b[i]) mem[a_b][8*i +: 8] <= d_b[8*i +: 8];
                if (wr_a && be_a[i]) mem[a_a][8*i +: 8] <= d_a[8*i +: 8];
            end
        end
    end

`ifdef RAM_DP_COLLISION_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) coll <= 1'b0;
        else coll <= run & en_a & en_b & (a_a == a_b) & (we_a | we_b);
    end
`endif
endmodule
